// File: rtl/axis_usb_packetizer.sv
// axis_usb_packetizer: frames an AXIS byte stream into USB bulk packets using a one-byte holding register.
// Define PACKETIZER_TIMEOUT_EN to build the idle counter that terminates a held partial packet.
module axis_usb_packetizer #(
    parameter int MAX_PACKET = 512,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        sys_clk,
    input  logic                        reset_n,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    input  logic [7:0]                  s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic                        flush_i,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [7:0]                  m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic [$clog2(MAX_PACKET):0] pkt_bytes_o
);
    localparam int CW = $clog2(MAX_PACKET) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_PACKET - 1);

    logic [7:0]    h_data_q, h_data_d, o_data_q, o_data_d;
    logic          h_valid_q, h_valid_d, h_last_q, h_last_d;
    logic          o_valid_q, o_valid_d, o_last_q, o_last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          out_free, acc, timed_out, promote, last;

    assign out_free      = !o_valid_q || m_axis_tready;
    assign s_axis_tready = reset_n && (!h_valid_q || out_free);
    assign acc           = s_axis_tvalid && s_axis_tready;
    assign promote       = h_valid_q && out_free && (acc || h_last_q || timed_out || flush_i);
    // A newly accepted byte takes over the flush/timeout termination from the byte it displaces
    assign last          = h_last_q || ((timed_out || flush_i) && !acc) || cnt_q == CNT_LAST;

`ifdef PACKETIZER_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_q, idle_d;
    assign timed_out = idle_q == IW'(TIMEOUT);
    always_comb idle_d = acc ? '0 : (h_valid_q && !h_last_q && !timed_out) ? idle_q + IW'(1) : idle_q;
    always_ff @(posedge sys_clk) idle_q <= !reset_n ? '0 : idle_d;
`else
    logic unused_timeout;
    assign unused_timeout = TIMEOUT != 0;
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        h_data_d  = acc ? s_axis_tdata : h_data_q;
        h_valid_d = acc || (h_valid_q && !promote);
        h_last_d  = acc ? (s_axis_tlast || flush_i) : h_last_q;
        o_valid_d = promote || (o_valid_q && !m_axis_tready);
        o_data_d  = promote ? h_data_q : o_data_q;
        o_last_d  = promote ? last : o_last_q;
        cnt_d     = !promote ? cnt_q : last ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge sys_clk) begin
        if (!reset_n) begin
            h_data_q  <= '0;
            h_valid_q <= 1'b0;
            h_last_q  <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            h_data_q  <= h_data_d;
            h_valid_q <= h_valid_d;
            h_last_q  <= h_last_d;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            cnt_q     <= cnt_d;
        end
    end

    assign m_axis_tvalid = o_valid_q;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tlast  = o_last_q;
    assign pkt_bytes_o   = cnt_q;
endmodule

// File: tb/tb_axis_usb_packetizer.sv
// tb_axis_usb_packetizer: directed bench for the packetizer; output bytes are checked against an expected-byte queue.
module tb_axis_usb_packetizer;
    localparam int MP = 512;
    localparam int TO = 16;

    logic                clk = 0, reset_n = 0, s_tvalid = 0, s_tlast = 0, flush = 0, m_tready = 1;
    logic [7:0]          s_tdata = 0;
    logic                s_tready, m_tvalid, m_tlast;
    logic [7:0]          m_tdata;
    logic [$clog2(MP):0] pkt;
    int                  errors = 0, checks = 0, n_out = 0, cyc = 0;
    int                  n0, c0;
    bit                  rand_mode = 0;
    logic [7:0]          exp_d[$];
    bit                  exp_l[$];
    logic                stalled = 0, held_l = 0;
    logic [7:0]          held_d = 0;

    axis_usb_packetizer #(.MAX_PACKET(MP), .TIMEOUT(TO)) dut (
        .sys_clk(clk), .reset_n(reset_n),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
        .s_axis_tlast(s_tlast), .flush_i(flush),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
        .m_axis_tlast(m_tlast), .pkt_bytes_o(pkt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_mode) m_tready = 1'($urandom_range(0, 1));
        #1;
    endtask

    task automatic push(input int d, input bit l);
        exp_d.push_back(8'(d));
        exp_l.push_back(l);
    endtask

    task automatic send(input int d, input bit l, input bit f);
        int n = 0;
        s_tvalid = 1;
        s_tdata  = 8'(d);
        s_tlast  = l;
        flush    = f;
        while (!s_tready && n < 100) begin
            step();
            n++;
        end
        check("send_ready", 32'(s_tready), 1);
        step();
        s_tvalid = 0;
        s_tlast  = 0;
        flush    = 0;
    endtask

    task automatic do_flush();
        flush = 1;
        step();
        flush = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_d.size() != 0 && n < 200) begin
            step();
            n++;
        end
        check("drain", exp_d.size(), 0);
    endtask

    always @(negedge clk) begin
        if (!reset_n) stalled <= 0;
        else begin
            if (stalled) begin
                check("stall_valid", 32'(m_tvalid), 1);
                check("stall_data", 32'(m_tdata), 32'(held_d));
                check("stall_last", 32'(m_tlast), 32'(held_l));
            end
            if (m_tvalid && m_tready) begin
                check("out_expected", 32'(exp_d.size() != 0), 1);
                if (exp_d.size() != 0) begin
                    check("out_data", 32'(m_tdata), 32'(exp_d.pop_front()));
                    check("out_last", 32'(m_tlast), 32'(exp_l.pop_front()));
                end
                n_out <= n_out + 1;
            end
            stalled <= m_tvalid && !m_tready;
            held_d  <= m_tdata;
            held_l  <= m_tlast;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) step();
        check("rst_s_tready", 32'(s_tready), 0);
        check("rst_m_tvalid", 32'(m_tvalid), 0);
        check("rst_m_tlast", 32'(m_tlast), 0);
        check("rst_m_tdata", 32'(m_tdata), 0);
        check("rst_pkt", 32'(pkt), 0);
        reset_n = 1;
        #1;
        check("rel_s_tready", 32'(s_tready), 1);
        step();

        n0 = n_out;
        c0 = cyc;
        for (int i = 0; i < 1024; i++) begin
            push(i, i % MP == MP - 1);
            send(i, 0, 0);
        end
        check("stream_cycles", cyc - c0, 1024);
        check("stream_outs", n_out - n0, 1022);
        check("stream_cnt", 32'(pkt), 511);
        do_flush();
        check("stream_pkt_end", 32'(pkt), 0);
        drain();

        for (int i = 0; i < 299; i++) begin
            push(i, 0);
            send(i, 0, 0);
        end
        push(299, 1);
        send(299, 1, 0);
        check("p300_cnt", 32'(pkt), 299);
        step();
        check("p300_restart", 32'(pkt), 0);
        for (int j = 0; j < 512; j++) begin
            push(j, j == 511);
            send(j, j == 511, 0);
        end
        step();
        check("p512_restart", 32'(pkt), 0);
        drain();
        n0 = n_out;
        repeat (5) step();
        check("no_empty_pkt", n_out - n0, 0);

        rand_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            push(i, i % MP == MP - 1 || i == 1999);
            send(i, 0, 0);
        end
        rand_mode = 0;
        step();
        m_tready = 1;
        step();
        do_flush();
        drain();
        check("rand_pkt_end", 32'(pkt), 0);

        n0 = n_out;
        do_flush();
        repeat (3) step();
        check("flush_empty_outs", n_out - n0, 0);
        check("flush_empty_valid", 32'(m_tvalid), 0);
        check("flush_empty_pkt", 32'(pkt), 0);
        push(8'hA0, 0);
        push(8'hA1, 0);
        push(8'hA2, 1);
        send(8'hA0, 0, 0);
        send(8'hA1, 0, 0);
        send(8'hA2, 0, 0);
        step();
        check("flush3_cnt", 32'(pkt), 2);
        do_flush();
        check("flush3_pkt", 32'(pkt), 0);
        drain();
        push(8'hB0, 0);
        push(8'hB1, 0);
        push(8'hB2, 1);
        send(8'hB0, 0, 0);
        send(8'hB1, 0, 0);
        send(8'hB2, 0, 1);
        check("flush_acc_cnt", 32'(pkt), 2);
        step();
        check("flush_acc_valid", 32'(m_tvalid), 1);
        check("flush_acc_last", 32'(m_tlast), 1);
        check("flush_acc_data", 32'(m_tdata), 32'hB2);
        check("flush_acc_pkt", 32'(pkt), 0);
        drain();

        for (int i = 0; i < 4; i++) push(8'hC0 + i, 0);
`ifdef PACKETIZER_TIMEOUT_EN
        push(8'hC4, 1);
`endif
        for (int i = 0; i < 5; i++) send(8'hC0 + i, 0, 0);
`ifdef PACKETIZER_TIMEOUT_EN
        repeat (TO) step();
        check("to_early", 32'(m_tvalid), 0);
        step();
        check("to_valid", 32'(m_tvalid), 1);
        check("to_last", 32'(m_tlast), 1);
        check("to_data", 32'(m_tdata), 32'hC4);
`else
        repeat (40) step();
        check("noto_valid", 32'(m_tvalid), 0);
        check("noto_cnt", 32'(pkt), 4);
        push(8'hC4, 1);
        do_flush();
`endif
        drain();
        check("to_pkt_end", 32'(pkt), 0);

        for (int i = 0; i < 200; i++) begin
            if (i < 198) push(i, 0);
            send(i, 0, 0);
        end
        reset_n = 0;
        step();
        check("midrst_valid", 32'(m_tvalid), 0);
        check("midrst_pkt", 32'(pkt), 0);
        check("midrst_ready", 32'(s_tready), 0);
        reset_n = 1;
        #1;
        check("midrst_rel_ready", 32'(s_tready), 1);
        for (int i = 0; i < 513; i++) begin
            push(i, i == 511 || i == 512);
            send(i, 0, i == 512);
        end
        drain();
        check("midrst_pkt_end", 32'(pkt), 0);

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
